// File: rtl/rsa_pkg.sv
// rsa_pkg: shared types and constants for the RSA core control blocks.
//   mmm_state_t    : sequencer states of the Montgomery multiplier controller
//   MMM_WIDTH_DFLT : default operand width (bits / Montgomery iterations)
//   idx_w()        : width of a bit index for a given operand width (min 1)
package rsa_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } mmm_state_t;

  localparam int MMM_WIDTH_DFLT = 4;

  function automatic int idx_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/mmm_iter_cnt.sv
// mmm_iter_cnt: step/bit counter pair for the Montgomery iteration loop.
//   clk, rstb      : clock, async active-low reset
//   ena            : clock enable, counters frozen when 0
//   clr            : synchronous clear of both counters (wins over run)
//   run            : advance step counter; bit index advances on each step_tick
//   bit_idx        : current multiplier bit index, wraps WIDTH-1 -> 0
//   step_tick      : last cycle of the current iteration (only while run)
//   last_bit       : bit_idx is at WIDTH-1
module mmm_iter_cnt
  import rsa_pkg::*;
#(
  parameter int WIDTH       = MMM_WIDTH_DFLT,
  parameter int STEP_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic                      ena,
  input  logic                      clr,
  input  logic                      run,
  output logic [idx_w(WIDTH)-1:0]   bit_idx,
  output logic                      step_tick,
  output logic                      last_bit
);

  localparam int IDX_W  = idx_w(WIDTH);
  localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WIDTH - 1);

  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;

  assign step_tick = run && (step_cnt_q == STEP_LAST);
  assign last_bit  = (bit_idx_q == IDX_LAST);
  assign bit_idx   = bit_idx_q;

  always_comb begin
    step_cnt_d = step_cnt_q;
    bit_idx_d  = bit_idx_q;
    if (ena) begin
      if (clr) begin
        step_cnt_d = '0;
        bit_idx_d  = '0;
      end else if (run) begin
        if (step_tick) begin
          step_cnt_d = '0;
          // wrap so the index is already 0 when the loop exits to FIX
          bit_idx_d  = last_bit ? '0 : bit_idx_q + 1'b1;
        end else begin
          step_cnt_d = step_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      step_cnt_q <= '0;
      bit_idx_q  <= '0;
    end else begin
      step_cnt_q <= step_cnt_d;
      bit_idx_q  <= bit_idx_d;
    end
  end

endmodule

// File: rtl/mmm_ctrl.sv
// mmm_ctrl: sequencer for the Montgomery modular-multiplication datapath.
//   clk, rstb : clock, async active-low reset
//   ena       : global clock enable (state frozen, strobes suppressed when 0)
//   start     : begin one multiplication (accepted only in IDLE)
//   abort     : synchronous abort back to IDLE, priority over start
//   r_ge_m    : partial result >= modulus, used in FIX
//   clear     : active-low clear of datapath registers
//   ld_r      : load strobe for partial-result registers
//   lock      : 1 = reload held value, 0 = load new value
//   bit_idx   : current multiplier bit index
//   busy      : operation in progress
//   done      : one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for start, all outputs inactive
// CLR   | one cycle of clear low to the datapath
// ITER  | WIDTH iterations of STEP_CYCLES each, ld_r on last step
// FIX   | conditional-subtract load, lock = ~r_ge_m
// DONE  | one-cycle done pulse, then back to IDLE
module mmm_ctrl
  import rsa_pkg::*;
#(
  parameter int WIDTH       = MMM_WIDTH_DFLT,
  parameter int STEP_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic                    ena,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    r_ge_m,
  output logic                    clear,
  output logic                    ld_r,
  output logic                    lock,
  output logic [idx_w(WIDTH)-1:0] bit_idx,
  output logic                    busy,
  output logic                    done
);

  mmm_state_t state_q, state_d;
  logic       cnt_clr, cnt_run, step_tick, last_bit;

  // counters are held at zero outside ITER so every run starts from bit 0
  assign cnt_clr = (state_q != ITER) || abort;
  assign cnt_run = (state_q == ITER);

  mmm_iter_cnt #(
    .WIDTH       (WIDTH),
    .STEP_CYCLES (STEP_CYCLES)
  ) u_iter_cnt (
    .clk       (clk),
    .rstb      (rstb),
    .ena       (ena),
    .clr       (cnt_clr),
    .run       (cnt_run),
    .bit_idx   (bit_idx),
    .step_tick (step_tick),
    .last_bit  (last_bit)
  );

  always_comb begin
    state_d = state_q;
    if (ena) begin
      if (abort && (state_q != IDLE)) begin
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE:    if (start && !abort) state_d = CLR;
          CLR:     state_d = ITER;
          ITER:    if (step_tick && last_bit) state_d = FIX;
          FIX:     state_d = DONE;
          DONE:    state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    clear = !(ena && (state_q == CLR));
    ld_r  = ena && ((state_q == FIX) || ((state_q == ITER) && step_tick));
    lock  = (state_q == FIX) && !r_ge_m;
    busy  = (state_q == CLR) || (state_q == ITER) || (state_q == FIX);
    done  = ena && (state_q == DONE);
  end

endmodule

// File: tb/tb_mmm_ctrl.sv
// Testbench for mmm_ctrl: two instances (STEP_CYCLES=1 and 3) share stimulus and
// are checked every cycle against a cycle-index reference model.
module tb_mmm_ctrl;

  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rstb, ena, start, abort, r_ge_m;
  logic       clear1, ld_r1, lock1, busy1, done1;
  logic       clear3, ld_r3, lock3, busy3, done3;
  logic [1:0] bidx1, bidx3;

  int errors = 0;
  int checks = 0;
  int k1 = -1;  // cycles since start was sampled; -1 = idle
  int k3 = -1;

  always #5 clk = ~clk;

  mmm_ctrl #(.WIDTH(W), .STEP_CYCLES(1)) u_s1 (
    .clk(clk), .rstb(rstb), .ena(ena), .start(start), .abort(abort), .r_ge_m(r_ge_m),
    .clear(clear1), .ld_r(ld_r1), .lock(lock1), .bit_idx(bidx1), .busy(busy1), .done(done1)
  );

  mmm_ctrl #(.WIDTH(W), .STEP_CYCLES(3)) u_s3 (
    .clk(clk), .rstb(rstb), .ena(ena), .start(start), .abort(abort), .r_ge_m(r_ge_m),
    .clear(clear3), .ld_r(ld_r3), .lock(lock3), .bit_idx(bidx3), .busy(busy3), .done(done3)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Expected outputs follow directly from the latency rules: CLR at 1,
  // iterations at 2..1+W*S, FIX at 2+W*S, done at 3+W*S.
  task automatic check_dut(input string nm, input int s, input int k,
                           input logic o_clr, input logic o_ld, input logic o_lk,
                           input logic [1:0] o_bi, input logic o_bs, input logic o_dn);
    int   fixk = 2 + W*s;
    int   j    = k - 2;
    bit   iter = (k >= 2) && (k <= 1 + W*s);
    logic [1:0] eb;
    eb = iter ? 2'(j / s) : 2'd0;
    chk({nm, ".clear"},   o_clr, !(ena && k == 1));
    chk({nm, ".ld_r"},    o_ld,  ena && ((iter && (j % s) == s - 1) || k == fixk));
    chk({nm, ".lock"},    o_lk,  (k == fixk) && !r_ge_m);
    chk({nm, ".bit_idx"}, o_bi,  eb);
    chk({nm, ".busy"},    o_bs,  (k >= 1) && (k <= fixk));
    chk({nm, ".done"},    o_dn,  ena && (k == fixk + 1));
  endtask

  function automatic int next_k(input int s, input int k, input logic e,
                                input logic st, input logic ab);
    if (!e)               return k;
    if (k < 0)            return (st && !ab) ? 1 : -1;
    if (ab)               return -1;
    if (k >= 3 + W*s)     return -1;
    return k + 1;
  endfunction

  task automatic cyc(input logic e, input logic st, input logic ab, input logic rg);
    @(negedge clk);
    ena = e; start = st; abort = ab; r_ge_m = rg;
    #1;
    check_dut("s1", 1, k1, clear1, ld_r1, lock1, bidx1, busy1, done1);
    check_dut("s3", 3, k3, clear3, ld_r3, lock3, bidx3, busy3, done3);
    k1 = next_k(1, k1, e, st, ab);
    k3 = next_k(3, k3, e, st, ab);
  endtask

  task automatic chk_reset_outputs();
    chk("rst.s1.clear", clear1, 1'b1); chk("rst.s1.ld_r", ld_r1, 1'b0);
    chk("rst.s1.lock",  lock1,  1'b0); chk("rst.s1.busy", busy1, 1'b0);
    chk("rst.s1.done",  done1,  1'b0); chk("rst.s1.bit_idx", bidx1, 2'd0);
    chk("rst.s3.clear", clear3, 1'b1); chk("rst.s3.ld_r", ld_r3, 1'b0);
    chk("rst.s3.lock",  lock3,  1'b0); chk("rst.s3.busy", busy3, 1'b0);
    chk("rst.s3.done",  done3,  1'b0); chk("rst.s3.bit_idx", bidx3, 2'd0);
  endtask

  initial begin
    rstb = 1'b0; ena = 1'b1; start = 1'b0; abort = 1'b0; r_ge_m = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk_reset_outputs();
    rstb = 1'b1;
    k1 = -1; k3 = -1;
    cyc(1, 0, 0, 0);

    // basic run, r_ge_m=0 in FIX
    cyc(1, 1, 0, 0);
    repeat (16) cyc(1, 0, 0, 0);

    // basic run, r_ge_m=1 in FIX (subtract path)
    cyc(1, 1, 0, 1);
    repeat (16) cyc(1, 0, 0, 1);

    // ena low for 3 cycles while s1 sits at bit_idx=2
    cyc(1, 1, 0, 0);
    repeat (3) cyc(1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);
    repeat (14) cyc(1, 0, 0, 0);

    // abort at s1 bit_idx=1 with a simultaneous start, then a clean run
    cyc(1, 1, 0, 0);
    repeat (2) cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 0);
    repeat (3) cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 1);
    repeat (16) cyc(1, 0, 0, 1);

    // start & abort together in IDLE
    cyc(1, 1, 1, 0);
    repeat (2) cyc(1, 0, 0, 0);

    // start pulses at cycles 5 and 15 ignored by s3, cycle 16 accepted
    for (int i = 0; i < 36; i++)
      cyc(1, (i == 0 || i == 5 || i == 15 || i == 16), 0, i[0]);

    // async reset in the middle of ITER
    cyc(1, 1, 0, 0);
    repeat (3) cyc(1, 0, 0, 0);
    @(negedge clk); ena = 1'b1; start = 1'b0;
    #2 rstb = 1'b0;
    #1 chk_reset_outputs();
    k1 = -1; k3 = -1;
    @(negedge clk); rstb = 1'b1;
    repeat (20) cyc(1, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      cyc(($urandom % 8) != 0, ($urandom % 4) == 0, ($urandom % 32) == 0, 1'($urandom));
    repeat (25) cyc(1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
